// File: rtl/stencil_pkg.sv
// stencil_pkg: shared types for the stencil RMW controller.
// Holds compare functions, stencil ops and controller FSM states.
package stencil_pkg;

  typedef enum logic [2:0] {
    F_NEVER,
    F_LESS,
    F_EQUAL,
    F_LEQUAL,
    F_GREATER,
    F_NOTEQUAL,
    F_GEQUAL,
    F_ALWAYS
  } stencil_func_t;

  typedef enum logic [2:0] {
    OP_KEEP,
    OP_ZERO,
    OP_REPLACE,
    OP_INCR,
    OP_DECR,
    OP_INVERT,
    OP_INCR_WRAP,
    OP_DECR_WRAP
  } stencil_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_TEST,
    S_WAIT_DEPTH,
    S_WRITE,
    S_RESP
  } ctrl_state_t;

endpackage

// File: rtl/stencil_op_unit.sv
// stencil_op_unit: combinational stencil op + write-mask merge.
// In: stored_i, ref_i, wmask_i, op_i. Out: new_o, changed_o.
module stencil_op_unit
  import stencil_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] stored_i,
  input  logic [W-1:0] ref_i,
  input  logic [W-1:0] wmask_i,
  input  stencil_op_t  op_i,
  output logic [W-1:0] new_o,
  output logic         changed_o
);

  logic [W-1:0] res;

  always_comb begin
    res = stored_i;
    unique case (op_i)
      OP_KEEP:      res = stored_i;
      OP_ZERO:      res = '0;
      OP_REPLACE:   res = ref_i;
      OP_INCR:      res = (&stored_i) ? stored_i
                                      : stored_i + W'(1);
      OP_DECR:      res = (~|stored_i) ? stored_i
                                       : stored_i - W'(1);
      OP_INVERT:    res = ~stored_i;
      OP_INCR_WRAP: res = stored_i + W'(1);
      OP_DECR_WRAP: res = stored_i - W'(1);
      default:      res = stored_i;
    endcase
  end

  assign new_o     = (stored_i & ~wmask_i) | (res & wmask_i);
  assign changed_o = (new_o != stored_i);

endmodule

// File: rtl/stencil_ctrl.sv
// stencil_ctrl: one-fragment-at-a-time stencil read/test/write FSM.
// Ports: fragment in, mem read/write, depth handshake, result out.
module stencil_ctrl
  import stencil_pkg::*;
#(
  parameter int STENCIL_SIZE = 8,
  parameter int ADDR_W       = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frag_valid_i,
  output logic                    frag_ready_o,
  input  logic [ADDR_W-1:0]       frag_addr_i,
  input  logic [STENCIL_SIZE-1:0] ref_val_i,
  input  logic [STENCIL_SIZE-1:0] func_mask_i,
  input  logic [STENCIL_SIZE-1:0] write_mask_i,
  input  logic [2:0]              stencil_func_i,
  input  logic [2:0]              sfail_op_i,
  input  logic [2:0]              dpfail_op_i,
  input  logic [2:0]              dppass_op_i,
  output logic                    mem_rd_req_o,
  output logic [ADDR_W-1:0]       mem_rd_addr_o,
  input  logic                    mem_rd_valid_i,
  input  logic [STENCIL_SIZE-1:0] mem_rd_data_i,
  input  logic                    depth_valid_i,
  output logic                    depth_ready_o,
  input  logic                    depth_pass_i,
  output logic                    mem_wr_en_o,
  output logic [ADDR_W-1:0]       mem_wr_addr_o,
  output logic [STENCIL_SIZE-1:0] mem_wr_data_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic                    stencil_pass_o,
  output logic                    pass_o
);

  localparam int S = STENCIL_SIZE;

  ctrl_state_t   state_q, state_d;
  logic          alive_q;
  logic [ADDR_W-1:0] addr_q;
  logic [S-1:0]  ref_q, fmask_q, wmask_q, stored_q;
  stencil_func_t func_q;
  stencil_op_t   sfail_q, dpfail_q, dppass_q;
  logic          spass_q, dpass_q;

  logic          accept, cmp_pass, changed;
  logic [S-1:0]  a, b, new_val;
  stencil_op_t   op_sel;

  assign accept = frag_valid_i & frag_ready_o;
  assign a      = ref_q & fmask_q;
  assign b      = stored_q & fmask_q;

  always_comb begin
    cmp_pass = 1'b0;
    unique case (func_q)
      F_NEVER:    cmp_pass = 1'b0;
      F_LESS:     cmp_pass = (a <  b);
      F_EQUAL:    cmp_pass = (a == b);
      F_LEQUAL:   cmp_pass = (a <= b);
      F_GREATER:  cmp_pass = (a >  b);
      F_NOTEQUAL: cmp_pass = (a != b);
      F_GEQUAL:   cmp_pass = (a >= b);
      F_ALWAYS:   cmp_pass = 1'b1;
      default:    cmp_pass = 1'b0;
    endcase
  end

  assign op_sel = !spass_q ? sfail_q
                : dpass_q  ? dppass_q
                           : dpfail_q;

  stencil_op_unit #(.W(S)) u_op (
    .stored_i  (stored_q),
    .ref_i     (ref_q),
    .wmask_i   (wmask_q),
    .op_i      (op_sel),
    .new_o     (new_val),
    .changed_o (changed)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (accept) state_d = S_READ;
      S_READ:       state_d = S_WAIT_RD;
      S_WAIT_RD:    if (mem_rd_valid_i) state_d = S_TEST;
      S_TEST:       state_d = cmp_pass ? S_WAIT_DEPTH
                                       : S_WRITE;
      S_WAIT_DEPTH: if (depth_valid_i) state_d = S_WRITE;
      S_WRITE:      state_d = S_RESP;
      S_RESP:       if (res_ready_i) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frag_ready_o   = 1'b0;
    mem_rd_req_o   = 1'b0;
    depth_ready_o  = 1'b0;
    mem_wr_en_o    = 1'b0;
    res_valid_o    = 1'b0;
    stencil_pass_o = 1'b0;
    pass_o         = 1'b0;
    mem_rd_addr_o  = '0;
    mem_wr_addr_o  = '0;
    mem_wr_data_o  = '0;
    unique case (state_q)
      // ready waits one clock after reset release
      S_IDLE:       frag_ready_o = alive_q;
      S_READ: begin
        mem_rd_req_o  = 1'b1;
        mem_rd_addr_o = addr_q;
      end
      S_WAIT_DEPTH: depth_ready_o = 1'b1;
      S_WRITE: begin
        mem_wr_en_o   = changed;
        mem_wr_addr_o = addr_q;
        mem_wr_data_o = new_val;
      end
      S_RESP: begin
        res_valid_o    = 1'b1;
        stencil_pass_o = spass_q;
        pass_o         = spass_q & dpass_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alive_q  <= 1'b0;
      addr_q   <= '0;
      ref_q    <= '0;
      fmask_q  <= '0;
      wmask_q  <= '0;
      stored_q <= '0;
      func_q   <= F_NEVER;
      sfail_q  <= OP_KEEP;
      dpfail_q <= OP_KEEP;
      dppass_q <= OP_KEEP;
      spass_q  <= 1'b0;
      dpass_q  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        addr_q   <= frag_addr_i;
        ref_q    <= ref_val_i;
        fmask_q  <= func_mask_i;
        wmask_q  <= write_mask_i;
        func_q   <= stencil_func_t'(stencil_func_i);
        sfail_q  <= stencil_op_t'(sfail_op_i);
        dpfail_q <= stencil_op_t'(dpfail_op_i);
        dppass_q <= stencil_op_t'(dppass_op_i);
        dpass_q  <= 1'b0;
      end
      if (state_q == S_WAIT_RD && mem_rd_valid_i)
        stored_q <= mem_rd_data_i;
      if (state_q == S_TEST)
        spass_q <= cmp_pass;
      if (state_q == S_WAIT_DEPTH && depth_valid_i)
        dpass_q <= depth_pass_i;
    end
  end

endmodule

// File: tb/tb_stencil_ctrl.sv
// tb_stencil_ctrl: directed scoreboard bench for stencil_ctrl.
// Drives/samples on negedge; expectations are hand-derived constants.
module tb_stencil_ctrl;
  import stencil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        frag_valid_i = 1'b0;
  logic        frag_ready_o;
  logic [19:0] frag_addr_i = '0;
  logic [7:0]  ref_val_i = '0;
  logic [7:0]  func_mask_i = '0;
  logic [7:0]  write_mask_i = '0;
  logic [2:0]  stencil_func_i = '0;
  logic [2:0]  sfail_op_i = '0;
  logic [2:0]  dpfail_op_i = '0;
  logic [2:0]  dppass_op_i = '0;
  logic        mem_rd_req_o;
  logic [19:0] mem_rd_addr_o;
  logic        mem_rd_valid_i = 1'b0;
  logic [7:0]  mem_rd_data_i = '0;
  logic        depth_valid_i = 1'b0;
  logic        depth_ready_o;
  logic        depth_pass_i = 1'b0;
  logic        mem_wr_en_o;
  logic [19:0] mem_wr_addr_o;
  logic [7:0]  mem_wr_data_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic        stencil_pass_o;
  logic        pass_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [19:0] addr;
    logic        wr;
    logic [7:0]  wd;
    logic        sp;
    logic        p;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  stencil_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .frag_valid_i   (frag_valid_i),
    .frag_ready_o   (frag_ready_o),
    .frag_addr_i    (frag_addr_i),
    .ref_val_i      (ref_val_i),
    .func_mask_i    (func_mask_i),
    .write_mask_i   (write_mask_i),
    .stencil_func_i (stencil_func_i),
    .sfail_op_i     (sfail_op_i),
    .dpfail_op_i    (dpfail_op_i),
    .dppass_op_i    (dppass_op_i),
    .mem_rd_req_o   (mem_rd_req_o),
    .mem_rd_addr_o  (mem_rd_addr_o),
    .mem_rd_valid_i (mem_rd_valid_i),
    .mem_rd_data_i  (mem_rd_data_i),
    .depth_valid_i  (depth_valid_i),
    .depth_ready_o  (depth_ready_o),
    .depth_pass_i   (depth_pass_i),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_wr_addr_o  (mem_wr_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .stencil_pass_o (stencil_pass_o),
    .pass_o         (pass_o)
  );

  function automatic logic [54:0] all_out();
    return {frag_ready_o, mem_rd_req_o, mem_rd_addr_o,
            depth_ready_o, mem_wr_en_o, mem_wr_addr_o,
            mem_wr_data_o, res_valid_o, stencil_pass_o,
            pass_o};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_frag(
    input logic [19:0] ad,
    input logic [7:0]  rf, fm, wm,
    input logic [2:0]  fn, sf, df, dp,
    input logic [7:0]  st,
    input logic        dres,
    input int          rw, dw, hold,
    input logic        ewr,
    input logic [7:0]  ewd,
    input logic        esp, ep,
    input int          elat);
    exp_t        e;
    int          edges, nwr, dcnt, lat;
    logic [7:0]  wd;
    logic [19:0] wa;
    bit          drdy, dgiven, done;
    e.addr = ad; e.wr = ewr; e.wd = ewd;
    e.sp = esp; e.p = ep; e.lat = elat;
    sb.push_back(e);
    nwr = 0; dcnt = 0; lat = 0;
    wd = '0; wa = '0;
    drdy = 0; dgiven = 0; done = 0;
    @(negedge clk);
    chk("frag_ready_idle", frag_ready_o, 1);
    frag_valid_i   = 1'b1;
    frag_addr_i    = ad;
    ref_val_i      = rf;
    func_mask_i    = fm;
    write_mask_i   = wm;
    stencil_func_i = fn;
    sfail_op_i     = sf;
    dpfail_op_i    = df;
    dppass_op_i    = dp;
    @(negedge clk);
    edges = 1;
    frag_valid_i   = 1'b0;
    frag_addr_i    = ~ad;
    ref_val_i      = ~rf;
    func_mask_i    = ~fm;
    write_mask_i   = ~wm;
    stencil_func_i = ~fn;
    sfail_op_i     = ~sf;
    dpfail_op_i    = ~df;
    dppass_op_i    = ~dp;
    chk("rd_req", mem_rd_req_o, 1);
    chk("rd_addr", mem_rd_addr_o, ad);
    chk("ready_busy", frag_ready_o, 0);
    mem_rd_valid_i = 1'b1;
    mem_rd_data_i  = ~st;
    @(negedge clk);
    edges++;
    chk("rd_req_once", mem_rd_req_o, 0);
    mem_rd_valid_i = 1'b0;
    repeat (rw) begin
      @(negedge clk);
      edges++;
    end
    mem_rd_valid_i = 1'b1;
    mem_rd_data_i  = st;
    @(negedge clk);
    edges++;
    mem_rd_valid_i = 1'b0;
    mem_rd_data_i  = ~st;
    depth_valid_i  = 1'b1;
    depth_pass_i   = ~dres;
    while (!done && edges < 60) begin
      @(negedge clk);
      edges++;
      depth_valid_i = 1'b0;
      if (mem_wr_en_o) begin
        nwr++;
        wd = mem_wr_data_o;
        wa = mem_wr_addr_o;
      end
      if (depth_ready_o) begin
        drdy = 1;
        if (!dgiven) begin
          if (dcnt == dw) begin
            depth_valid_i = 1'b1;
            depth_pass_i  = dres;
            dgiven = 1;
          end else dcnt++;
        end
      end
      if (res_valid_o) begin
        done = 1;
        lat  = edges;
      end
    end
    chk("res_seen", done, 1);
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("wr_count", nwr, e.wr ? 1 : 0);
    if (e.wr) begin
      chk("wr_data", wd, e.wd);
      chk("wr_addr", wa, e.addr);
    end
    chk("stencil_pass", stencil_pass_o, e.sp);
    chk("pass", pass_o, e.p);
    chk("depth_ready_seen", drdy, e.sp);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_stable",
          {res_valid_o, stencil_pass_o, pass_o,
           frag_ready_o, mem_wr_en_o},
          {1'b1, e.sp, e.p, 1'b0, 1'b0});
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("post_hs", {res_valid_o, frag_ready_o}, 2'b01);
  endtask

  initial begin
    int nwr, nres;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_out(), 55'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", frag_ready_o, 1);
    chk("no_strobes",
        {mem_rd_req_o, mem_wr_en_o, res_valid_o}, 3'b000);

    run_frag(20'h00123, 8'h05, 8'hFF, 8'hFF, F_LESS,
             OP_KEEP, OP_KEEP, OP_INCR, 8'h09, 1'b1,
             0, 0, 0, 1'b1, 8'h0A, 1'b1, 1'b1, 6);
    run_frag(20'hABCDE, 8'h03, 8'hFF, 8'hFF, F_EQUAL,
             OP_ZERO, OP_KEEP, OP_KEEP, 8'h04, 1'b1,
             0, 0, 0, 1'b1, 8'h00, 1'b0, 1'b0, 5);
    run_frag(20'h00001, 8'h00, 8'hFF, 8'hFF, F_ALWAYS,
             OP_KEEP, OP_KEEP, OP_INCR, 8'hFF, 1'b1,
             0, 0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 6);
    run_frag(20'h00002, 8'h00, 8'hFF, 8'hFF, F_ALWAYS,
             OP_KEEP, OP_KEEP, OP_INCR_WRAP, 8'hFF, 1'b1,
             0, 0, 0, 1'b1, 8'h00, 1'b1, 1'b1, 6);
    run_frag(20'h00003, 8'h00, 8'hFF, 8'hFF, F_ALWAYS,
             OP_KEEP, OP_KEEP, OP_DECR, 8'h00, 1'b1,
             0, 0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 6);
    run_frag(20'h00004, 8'h00, 8'hFF, 8'hFF, F_ALWAYS,
             OP_KEEP, OP_KEEP, OP_DECR_WRAP, 8'h00, 1'b1,
             0, 0, 0, 1'b1, 8'hFF, 1'b1, 1'b1, 6);
    run_frag(20'h4F00F, 8'hAB, 8'hFF, 8'h0F, F_ALWAYS,
             OP_KEEP, OP_KEEP, OP_REPLACE, 8'h50, 1'b1,
             0, 0, 0, 1'b1, 8'h5B, 1'b1, 1'b1, 6);
    run_frag(20'h00777, 8'h00, 8'hFF, 8'hFF, F_ALWAYS,
             OP_ZERO, OP_KEEP, OP_ZERO, 8'h77, 1'b0,
             0, 1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 7);
    run_frag(20'h12345, 8'h1F, 8'h0F, 8'hFF, F_GREATER,
             OP_INVERT, OP_KEEP, OP_KEEP, 8'h2F, 1'b1,
             2, 0, 0, 1'b1, 8'hD0, 1'b0, 1'b0, 7);
    run_frag(20'h00AAA, 8'h33, 8'hFF, 8'hFF, F_NEVER,
             OP_REPLACE, OP_KEEP, OP_KEEP, 8'h10, 1'b1,
             0, 0, 0, 1'b1, 8'h33, 1'b0, 1'b0, 5);
    run_frag(20'h00BBB, 8'h10, 8'hFF, 8'hFF, F_GEQUAL,
             OP_KEEP, OP_DECR, OP_ZERO, 8'h10, 1'b0,
             0, 3, 0, 1'b1, 8'h0F, 1'b1, 1'b0, 9);
    run_frag(20'h00CCC, 8'h09, 8'hFF, 8'hFF, F_LEQUAL,
             OP_INCR, OP_KEEP, OP_KEEP, 8'h05, 1'b1,
             0, 0, 0, 1'b1, 8'h06, 1'b0, 1'b0, 5);
    run_frag(20'h00DDD, 8'h01, 8'hFF, 8'hFF, F_NOTEQUAL,
             OP_KEEP, OP_KEEP, OP_INVERT, 8'h02, 1'b1,
             0, 0, 5, 1'b1, 8'hFD, 1'b1, 1'b1, 6);

    @(negedge clk);
    frag_valid_i   = 1'b1;
    frag_addr_i    = 20'h0EEEE;
    stencil_func_i = F_ALWAYS;
    dppass_op_i    = OP_INVERT;
    dpfail_op_i    = OP_INVERT;
    write_mask_i   = 8'hFF;
    @(negedge clk);
    frag_valid_i = 1'b0;
    @(negedge clk);
    mem_rd_valid_i = 1'b1;
    mem_rd_data_i  = 8'h12;
    @(negedge clk);
    mem_rd_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_in_wait_depth", depth_ready_o, 1);
    rst_i = 1'b1;
    #1;
    chk("rst_async_outs", all_out(), 55'd0);
    @(negedge clk);
    chk("rst_held_outs", all_out(), 55'd0);
    rst_i = 1'b0;
    nwr = 0;
    nres = 0;
    @(negedge clk);
    chk("rst_back_idle",
        {frag_ready_o, depth_ready_o}, 2'b10);
    repeat (5) begin
      @(negedge clk);
      if (mem_wr_en_o) nwr++;
      if (res_valid_o) nres++;
    end
    chk("rst_no_wr", nwr, 0);
    chk("rst_no_res", nres, 0);

    run_frag(20'h00042, 8'h05, 8'hFF, 8'hFF, F_LESS,
             OP_KEEP, OP_KEEP, OP_INCR, 8'h09, 1'b1,
             0, 0, 0, 1'b1, 8'h0A, 1'b1, 1'b1, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
